axi4_lite_read_master: RTL
==========================

# axi4_lite_read_master

AXI4-Lite read-channel initiator that turns single-word local read requests into AR/R channel transactions and returns the read data and response to the requester. It sits between a local requester (core load unit or bus bridge) and the AXI4-Lite interconnect, pairing with the existing read slave on the far side. It handles exactly one outstanding read at a time, with an optional watchdog that aborts reads from an unresponsive slave.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when the watchdog is compiled in; must be ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  local read request
- req_addr  in  ADDR_WIDTH  local read address
- req_ready  out  1  master idle, can accept a request
- resp_valid  out  1  one-cycle pulse: read result available
- resp_data  out  DATA_WIDTH  read data; valid with resp_valid
- resp_code  out  2  RRESP captured, or local timeout code; valid with resp_valid
- resp_err  out  1  resp_code != 2'b00; valid with resp_valid
- M_AXI_ARADDR  out  ADDR_WIDTH  read address
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  slave accepts address
- M_AXI_RDATA  in  DATA_WIDTH  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  master accepts data

## Operation
- States: ST_IDLE, ST_ADDR, ST_DATA, ST_RESP. All outputs are registered or decoded from state; no combinational input-to-output path.
- ST_IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr into M_AXI_ARADDR and go to ST_ADDR.
- ST_ADDR:
  - M_AXI_ARVALID=1; M_AXI_ARADDR held stable.
  - On M_AXI_ARREADY, go to ST_DATA.
  - ARVALID is never withdrawn before the handshake except on watchdog abort.
- ST_DATA:
  - M_AXI_RREADY=1.
  - On M_AXI_RVALID, capture RDATA into resp_data and RRESP into resp_code, then go to ST_RESP.
- ST_RESP:
  - resp_valid=1 for exactly one cycle; resp_err = |resp_code.
  - Unconditionally return to ST_IDLE. The requester has no back-pressure.
- resp_data and resp_code hold their last values until the next capture.
- M_AXI_ARADDR holds its last value.
- req_valid outside ST_IDLE is ignored and not queued.
- RVALID arriving in ST_IDLE or ST_ADDR is ignored, since RREADY=0; a compliant slave never does this.
- An ARREADY level held high while idle has no effect.

## Timing
- Reset values: every output is 0, state is ST_IDLE, the timeout counter is 0. Reset is asynchronous; assertion mid-transaction immediately drops ARVALID/RREADY and discards the transaction.
- Request accepted on edge N (req_valid && req_ready):
  - ARVALID=1 from cycle N+1.
  - With ARREADY=1 at N+1, RREADY=1 from N+2.
  - With RVALID=1 at N+2, resp_valid=1 at N+3.
  - req_ready=1 again at N+4.
- Minimum request-to-response latency: 3 cycles. Minimum issue interval: 4 cycles.
- Each handshake takes one cycle with VALID&&READY high on a rising edge. Wait states on either channel extend ST_ADDR or ST_DATA indefinitely, unless the watchdog is compiled in.

## Configuration
- Macro: AXI4_LITE_READ_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ST_ADDR and increments every cycle in ST_ADDR or ST_DATA.
  - When it reaches TIMEOUT_CYCLES without the R handshake, the master drops ARVALID/RREADY and goes to ST_RESP with resp_code=2'b11, resp_err=1, resp_data=0.
  - If the handshake completes on the same edge the count reaches TIMEOUT_CYCLES, the handshake wins.
  - Any later RVALID from the aborted read is ignored.
  - The abort is a deliberate deadlock escape for a dead slave and is not AXI-compliant behaviour.
- Undefined: no counter logic, TIMEOUT_CYCLES unused, waits unbounded.

## Test plan
- Zero-wait read: req addr 0x0000_0010, slave ARREADY=1, RVALID at first RREADY cycle with RDATA 0xDEAD_BEEF, RRESP 0 -> ARVALID N+1, RREADY N+2, resp_valid N+3 with data 0xDEAD_BEEF, resp_err 0.
- Wait states: ARREADY delayed 3 cycles, RVALID delayed 5 cycles -> ARVALID/ARADDR stable for 4 cycles, RREADY high 6 cycles, one resp_valid pulse.
- Error response: RRESP=2'b10, RDATA 0x1234_5678 -> resp_code 2'b10, resp_err 1, data 0x1234_5678.
- Busy/back-to-back: req_valid held high with changing addresses -> only the address sampled in ST_IDLE is issued, one transaction per 4 cycles minimum, no lost or duplicated responses.
- Async reset asserted in ST_DATA -> ARVALID, RREADY, resp_valid and req_ready are 0 without waiting for a clock edge; after release req_ready=1 and no stale resp_valid.
- With AXI4_LITE_READ_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts ARREADY -> resp_valid with resp_code 2'b11 and data 0 exactly 8 cycles after ARVALID rises, then idle. Without the macro -> ARVALID stays high indefinitely.

Source files
------------

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite read initiator: one outstanding single-word read, AR/R handshakes, one-cycle response pulse.
// Optional watchdog abort for a dead slave: define AXI4_LITE_READ_MASTER_TIMEOUT_EN.
module axi4_lite_read_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [1:0]            resp_code,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t                  state_r;
   logic                    req_ready_r;
   logic                    resp_valid_r;
   logic                    resp_err_r;
   logic [DATA_WIDTH-1:0]   resp_data_r;
   logic [1:0]              resp_code_r;
   logic [ADDR_WIDTH-1:0]   araddr_r;
   logic                    arvalid_r;
   logic                    rready_r;
   logic                    expire_s;

`ifdef AXI4_LITE_READ_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;

   // Expiry fires on the edge where the count would reach TIMEOUT_CYCLES.
   assign expire_s = (cnt_r == CNT_LAST);

   // Watchdog count: zero while idle, advances every cycle spent waiting on the slave.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (state_r == ST_IDLE) begin
         cnt_r <= '0;
      end else if ((state_r == ST_ADDR) || (state_r == ST_DATA)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end
`else
   assign expire_s = 1'b0;
`endif

   // Transaction FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_data_r  <= '0;
         resp_code_r  <= 2'b00;
         araddr_r     <= '0;
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               resp_valid_r <= 1'b0;
               if (req_valid && req_ready_r) begin
                  araddr_r    <= req_addr;
                  arvalid_r   <= 1'b1;
                  req_ready_r <= 1'b0;
                  state_r     <= ST_ADDR;
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (expire_s) begin
                  arvalid_r    <= 1'b0;
                  rready_r     <= 1'b0;
                  resp_data_r  <= '0;
                  resp_code_r  <= 2'b11;
                  resp_err_r   <= 1'b1;
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_RESP;
               end else if (M_AXI_ARREADY) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= ST_DATA;
               end else begin
                  state_r <= ST_ADDR;
               end
            end
            ST_DATA: begin
               // A real R handshake takes priority over an expiry on the same edge.
               if (M_AXI_RVALID) begin
                  rready_r     <= 1'b0;
                  resp_data_r  <= M_AXI_RDATA;
                  resp_code_r  <= M_AXI_RRESP;
                  resp_err_r   <= |M_AXI_RRESP;
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_RESP;
               end else if (expire_s) begin
                  arvalid_r    <= 1'b0;
                  rready_r     <= 1'b0;
                  resp_data_r  <= '0;
                  resp_code_r  <= 2'b11;
                  resp_err_r   <= 1'b1;
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_RESP;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_RESP: begin
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= ST_IDLE;
            end
            default: begin
               arvalid_r    <= 1'b0;
               rready_r     <= 1'b0;
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_r;
   assign resp_valid    = resp_valid_r;
   assign resp_data     = resp_data_r;
   assign resp_code     = resp_code_r;
   assign resp_err      = resp_err_r;
   assign M_AXI_ARADDR  = araddr_r;
   assign M_AXI_ARVALID = arvalid_r;
   assign M_AXI_RREADY  = rready_r;

endmodule
